// File: rtl/frame_sync_pkg.sv
// Shared types and default constants for the frame_sync block.
// Optional feature macro used by the block: FRAME_SYNC_POLARITY_EN.
package frame_sync_pkg;

    // Synchroniser states, 2-bit encoding.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCK    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam int              PRE_MIN     = 32;
    localparam int              SFD_WIDTH   = 16;
    localparam logic [15:0]     SFD         = 16'b1101000000001000;
    localparam int              SFD_TIMEOUT = 128;
    localparam int              PAYLOAD_LEN = 176;

    // Width of a counter that must hold values 0..max.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/frame_sync_if.sv
// Serial line and framed payload bundle between the line side and Receiver.
//
// Handshake: Valid qualifies Output for exactly one cycle per payload bit;
// there is no back-pressure (no ready), the receiver must accept every
// cycle in which Valid is high. FrameStart/FrameEnd are only ever high
// together with Valid. Input is one serial bit per clock, always consumed.
interface frame_sync_if;
    logic Input;
    logic Output;
    logic Valid;
    logic FrameStart;
    logic FrameEnd;
    logic Locked;
    logic Error;

    // Line driver / receiver side.
    modport master (
        output Input,
        input  Output, Valid, FrameStart, FrameEnd, Locked, Error
    );

    // Synchroniser side.
    modport slave (
        input  Input,
        output Output, Valid, FrameStart, FrameEnd, Locked, Error
    );
endinterface

// File: rtl/frame_sync_sfd_correlator.sv
// Start-frame-delimiter correlator: bit history plus equality compare.
// The compared window is the stored history with the current bit appended,
// so a match is reported in the same cycle the last SFD bit arrives.
// FRAME_SYNC_POLARITY_EN: also report a match against the inverted SFD.
module sfd_correlator #(
    parameter int                   SFD_WIDTH = frame_sync_pkg::SFD_WIDTH,
    parameter logic [SFD_WIDTH-1:0] SFD       = frame_sync_pkg::SFD
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match,
    output logic match_inv
);

    // Only SFD_WIDTH-1 bits need storing: the newest bit is the live input.
    logic [SFD_WIDTH-2:0] hist_q, hist_d;
    logic [SFD_WIDTH-1:0] window;

    // Build the compare window and the next history value.
    always_comb begin
        window = {hist_q, bit_in};
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (shift_en) begin
            hist_d = window[SFD_WIDTH-2:0];
        end
    end

    // History register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign match = shift_en && (window == SFD);

`ifdef FRAME_SYNC_POLARITY_EN
    assign match_inv = shift_en && (window == ~SFD);
`else
    assign match_inv = 1'b0;
`endif

endmodule

// File: rtl/frame_sync.sv
// Serial frame synchroniser: hunts for an alternating preamble, locks,
// waits for the SFD, then forwards PAYLOAD_LEN bits with framing strobes.
// FRAME_SYNC_POLARITY_EN: an inverted SFD is accepted and the payload of
// that frame is re-inverted before it is forwarded.
module frame_sync #(
    parameter int                   PRE_MIN     = frame_sync_pkg::PRE_MIN,
    parameter int                   SFD_WIDTH   = frame_sync_pkg::SFD_WIDTH,
    parameter logic [SFD_WIDTH-1:0] SFD         = frame_sync_pkg::SFD,
    parameter int                   SFD_TIMEOUT = frame_sync_pkg::SFD_TIMEOUT,
    parameter int                   PAYLOAD_LEN = frame_sync_pkg::PAYLOAD_LEN
) (
    input  logic                   Clock,
    input  logic                   Reset,
    frame_sync_if.slave            bus,
    output frame_sync_pkg::state_t state_dbg
);
    import frame_sync_pkg::*;

    localparam int AW = cnt_width(PRE_MIN);
    localparam int TW = cnt_width(SFD_TIMEOUT);
    localparam int PW = cnt_width(PAYLOAD_LEN);

    localparam logic [AW-1:0] ALT_MAX  = AW'(PRE_MIN);
    localparam logic [AW-1:0] ALT_ONE  = AW'(1);
    localparam logic [TW-1:0] TB_MAX   = TW'(SFD_TIMEOUT);
    localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);

    state_t        state_q, state_d;
    logic          prev_q, prev_d;
    logic [AW-1:0] alt_cnt_q, alt_cnt_d;
    logic [TW-1:0] tb_cnt_q, tb_cnt_d;
    logic [PW-1:0] pay_cnt_q, pay_cnt_d;
    logic          inv_q, inv_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          end_q, end_d;
    logic          err_q, err_d;

    logic          match, match_inv;

    sfd_correlator #(
        .SFD_WIDTH (SFD_WIDTH),
        .SFD       (SFD)
    ) u_corr (
        .Clock     (Clock),
        .Reset     (Reset),
        .clear     (state_q == HUNT),
        .shift_en  (state_q == LOCK),
        .bit_in    (bus.Input),
        .match     (match),
        .match_inv (match_inv)
    );

    // Next-state and registered-output logic for the synchroniser FSM.
    always_comb begin
        state_d   = state_q;
        prev_d    = bus.Input;
        alt_cnt_d = alt_cnt_q;
        tb_cnt_d  = tb_cnt_q;
        pay_cnt_d = pay_cnt_q;
        inv_d     = inv_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            HUNT: begin
                inv_d     = 1'b0;
                tb_cnt_d  = '0;
                pay_cnt_d = '0;
                // A zero count means no previous bit yet: this bit starts a run of one.
                if (alt_cnt_q == '0 || bus.Input == prev_q) begin
                    alt_cnt_d = ALT_ONE;
                end else if (alt_cnt_q != ALT_MAX) begin
                    alt_cnt_d = alt_cnt_q + 1'b1;
                end
                if (alt_cnt_d == ALT_MAX) begin
                    state_d = LOCK;
                end
            end

            LOCK: begin
                tb_cnt_d = tb_cnt_q + 1'b1;
                // A match on the final allowed bit still wins over the timeout.
                if (match || match_inv) begin
                    state_d   = PAYLOAD;
                    pay_cnt_d = '0;
                    inv_d     = match_inv && !match;
                end else if (tb_cnt_d == TB_MAX) begin
                    err_d     = 1'b1;
                    state_d   = HUNT;
                    alt_cnt_d = '0;
                    tb_cnt_d  = '0;
                end
            end

            PAYLOAD: begin
                out_d   = bus.Input ^ inv_q;
                valid_d = 1'b1;
                start_d = (pay_cnt_q == '0);
                end_d   = (pay_cnt_q == PAY_LAST);
                if (pay_cnt_q == PAY_LAST) begin
                    state_d   = HUNT;
                    pay_cnt_d = '0;
                    alt_cnt_d = '0;
                    tb_cnt_d  = '0;
                end else begin
                    pay_cnt_d = pay_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = HUNT;
                alt_cnt_d = '0;
                tb_cnt_d  = '0;
                pay_cnt_d = '0;
                inv_d     = 1'b0;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= HUNT;
            prev_q    <= 1'b0;
            alt_cnt_q <= '0;
            tb_cnt_q  <= '0;
            pay_cnt_q <= '0;
            inv_q     <= 1'b0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            alt_cnt_q <= alt_cnt_d;
            tb_cnt_q  <= tb_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            inv_q     <= inv_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    assign bus.Output     = out_q;
    assign bus.Valid      = valid_q;
    assign bus.FrameStart = start_q;
    assign bus.FrameEnd   = end_q;
    assign bus.Error      = err_q;
    assign bus.Locked     = (state_q != HUNT);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync with a payload scoreboard.
// Build with FRAME_SYNC_POLARITY_EN defined to exercise the inverted SFD path.
module tb_frame_sync;
    import frame_sync_pkg::*;

    localparam int W = 3;   // {FrameStart, FrameEnd, Output}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_sync_if bus();
    state_t       state_dbg;

    frame_sync dut (
        .Clock     (clk),
        .Reset     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / counters ----------------
    logic [W-1:0]         exp_q[$];
    logic [SFD_WIDTH-1:0] sfd_v;
    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int start_cnt = 0;
    int end_cnt   = 0;
    int err_cnt   = 0;
    int lock_cnt  = 0;
    int v0, s0, e0, r0, l0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the DUT samples Input at the edge, outputs are read 1ns later.
    task automatic step();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (bus.Valid)      valid_cnt++;
        if (bus.FrameStart) start_cnt++;
        if (bus.FrameEnd)   end_cnt++;
        if (bus.Error)      err_cnt++;
        if (bus.Locked)     lock_cnt++;
        if (bus.Valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.Valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("payload", 32'({bus.FrameStart, bus.FrameEnd, bus.Output}), 32'(e));
            end
        end else if (bus.FrameStart || bus.FrameEnd) begin
            check("strobe_without_valid", 32'({bus.FrameStart, bus.FrameEnd}), 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        bus.Input = b;
        step();
    endtask

    task automatic send_alt(input int n, input logic first);
        for (int i = 0; i < n; i++) send_bit(first ^ i[0]);
    endtask

    task automatic send_sfd(input logic inv);
        for (int i = SFD_WIDTH - 1; i >= 0; i--) send_bit(sfd_v[i] ^ inv);
    endtask

    // Payload bit i is expected on Output with FrameStart at i==0, FrameEnd at the last bit.
    task automatic send_payload(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            exp_q.push_back({(i == 0), (i == PAYLOAD_LEN - 1), b});
            send_bit(b ^ inv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Input = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic snap();
        v0 = valid_cnt; s0 = start_cnt; e0 = end_cnt; r0 = err_cnt; l0 = lock_cnt;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        sfd_v = SFD;
        rst = 1'b1;
        bus.Input = 1'b0;
        repeat (3) step();
        check("reset_outputs", 32'({bus.Output, bus.Valid, bus.FrameStart, bus.FrameEnd,
                                    bus.Locked, bus.Error}), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(HUNT));
        rst = 1'b0;

        // 1: long preamble, SFD, full random frame
        snap();
        send_alt(31, 1'b1);
        check("t1_not_locked_31", 32'(bus.Locked), 32'd0);
        send_alt(1, 1'b0);
        check("t1_locked_32", 32'(bus.Locked), 32'd1);
        send_alt(64, 1'b1);
        check("t1_still_locked", 32'(state_dbg), 32'(LOCK));
        send_sfd(1'b0);
        check("t1_payload_state", 32'(state_dbg), 32'(PAYLOAD));
        send_payload(PAYLOAD_LEN, 1'b0);
        check("t1_valid_cycles", 32'(valid_cnt - v0), 32'(PAYLOAD_LEN));
        check("t1_starts", 32'(start_cnt - s0), 32'd1);
        check("t1_ends", 32'(end_cnt - e0), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_unlocked_after_end", 32'(bus.Locked), 32'd0);
        send_bit(1'b0);
        check("t1_valid_drops", 32'(bus.Valid), 32'd0);
        check("t1_no_error", 32'(err_cnt - r0), 32'd0);

        // 2: short preamble then idle zeros: never locks
        do_reset();
        snap();
        send_alt(20, 1'b1);
        repeat (200) send_bit(1'b0);
        check("t2_never_locked", 32'(lock_cnt - l0), 32'd0);
        check("t2_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t2_no_error", 32'(err_cnt - r0), 32'd0);

        // 3: lock then no SFD: error on the 128th bit after lock
        do_reset();
        snap();
        send_alt(40, 1'b1);
        check("t3_locked", 32'(bus.Locked), 32'd1);
        repeat (119) send_bit(1'b0);
        check("t3_locked_127", 32'(bus.Locked), 32'd1);
        check("t3_no_error_yet", 32'(err_cnt - r0), 32'd0);
        send_bit(1'b0);
        check("t3_error_pulse", 32'(bus.Error), 32'd1);
        check("t3_unlocked_with_error", 32'(bus.Locked), 32'd0);
        send_bit(1'b0);
        check("t3_error_one_cycle", 32'(bus.Error), 32'd0);
        repeat (50) send_bit(1'b0);
        check("t3_error_count", 32'(err_cnt - r0), 32'd1);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);

        // 4: reset in the middle of the payload, then a clean frame
        do_reset();
        send_alt(32, 1'b1);
        send_sfd(1'b0);
        send_payload(49, 1'b0);
        snap();
        rst = 1'b1;
        bus.Input = 1'b1;
        step();
        rst = 1'b0;
        check("t4_valid_after_reset", 32'(bus.Valid), 32'd0);
        check("t4_locked_after_reset", 32'(bus.Locked), 32'd0);
        check("t4_state_after_reset", 32'(state_dbg), 32'(HUNT));
        check("t4_no_frame_end", 32'(end_cnt - e0), 32'd0);
        check("t4_no_error", 32'(err_cnt - r0), 32'd0);
        snap();
        send_alt(32, 1'b1);
        send_sfd(1'b0);
        send_payload(PAYLOAD_LEN, 1'b0);
        check("t4_second_valid", 32'(valid_cnt - v0), 32'(PAYLOAD_LEN));
        check("t4_second_end", 32'(end_cnt - e0), 32'd1);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: two frames back-to-back, minimum preamble each
        do_reset();
        snap();
        repeat (2) begin
            send_alt(32, 1'b1);
            send_sfd(1'b0);
            send_payload(PAYLOAD_LEN, 1'b0);
        end
        check("t5_starts", 32'(start_cnt - s0), 32'd2);
        check("t5_ends", 32'(end_cnt - e0), 32'd2);
        check("t5_valid_cycles", 32'(valid_cnt - v0), 32'(2 * PAYLOAD_LEN));
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: inverted SFD
        do_reset();
        snap();
        send_alt(32, 1'b1);
        send_sfd(1'b1);
`ifdef FRAME_SYNC_POLARITY_EN
        check("t6_inv_payload_state", 32'(state_dbg), 32'(PAYLOAD));
        send_payload(PAYLOAD_LEN, 1'b1);
        check("t6_inv_valid", 32'(valid_cnt - v0), 32'(PAYLOAD_LEN));
        check("t6_inv_ends", 32'(end_cnt - e0), 32'd1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t6_no_error", 32'(err_cnt - r0), 32'd0);
`else
        check("t6_inv_ignored", 32'(state_dbg), 32'(LOCK));
        repeat (111) send_bit(1'b1);
        check("t6_no_error_yet", 32'(err_cnt - r0), 32'd0);
        send_bit(1'b1);
        check("t6_timeout_error", 32'(bus.Error), 32'd1);
        check("t6_unlocked", 32'(bus.Locked), 32'd0);
        check("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
`endif

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
